// File: rtl/multicycle_controller_if.sv
// Control bundle between the multi-cycle controller and its datapath.
// master = controller side, slave = datapath side.
interface multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_sel;
  logic [1:0] imm_src;
  logic       reg_write;
  logic       illegal;

  modport master (
    input  op, funct3, funct7b5, zero,
    output pc_write, adr_src, mem_write, ir_write, result_src,
           alu_src_a, alu_src_b, alu_sel, imm_src, reg_write, illegal
  );

  modport slave (
    output op, funct3, funct7b5, zero,
    input  pc_write, adr_src, mem_write, ir_write, result_src,
           alu_src_a, alu_src_b, alu_sel, imm_src, reg_write, illegal
  );
endinterface

// File: rtl/multicycle_controller.sv
// Main control FSM for the multi-cycle RV32I-subset datapath.
// state    | meaning
// FETCH    | read IR at PC, PC <= PC+4
// DECODE   | branch target into ALUOut, dispatch or flag illegal
// MEMADR   | rs1 + imm address for lw/sw
// MEMREAD  | read data memory at ALUOut
// MEMWB    | write loaded data to rd
// MEMWRITE | store rs2 at ALUOut
// EXECR    | register-register ALU op
// EXECI    | register-immediate ALU op
// ALUWB    | write ALUOut to rd
// BRANCH   | compare rs1/rs2, conditionally load PC from ALUOut
// JAL      | PC <= ALUOut, compute OldPC+4 for the link
module multicycle_controller (
  input  logic                   clk,
  input  logic                   rst,
  multicycle_controller_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  state_t state, state_nxt, cur;

  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_sel;
  logic       r_ok, i_ok, b_ok;

  // Reset presents FETCH outputs immediately, even before the first edge.
  assign cur = rst ? S_FETCH : state;

  assign r_ok = (bus.funct3 == 3'b000) ||
                (((bus.funct3 == 3'b110) || (bus.funct3 == 3'b111)) && !bus.funct7b5);
  assign i_ok = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b110) || (bus.funct3 == 3'b111);
  assign b_ok = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b001);

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nxt;
  end

  always_comb begin
    imm_src = 2'b00;
    case (bus.op)
      OP_SW:   imm_src = 2'b01;
      OP_BR:   imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

  always_comb begin
    state_nxt  = S_FETCH;
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    illegal    = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_sel    = ALU_ADD;

    case (cur)
      S_FETCH: begin
        ir_write   = 1'b1;
        pc_write   = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        state_nxt  = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (bus.op)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_R:   if (r_ok) state_nxt = S_EXECR;  else illegal = 1'b1;
          OP_I:   if (i_ok) state_nxt = S_EXECI;  else illegal = 1'b1;
          OP_BR:  if (b_ok) state_nxt = S_BRANCH; else illegal = 1'b1;
          OP_JAL: state_nxt = S_JAL;
          default: illegal = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_nxt = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src   = 1'b1;
        state_nxt = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        case (bus.funct3)
          3'b000:  alu_sel = bus.funct7b5 ? ALU_SUB : ALU_ADD;
          3'b111:  alu_sel = ALU_AND;
          3'b110:  alu_sel = ALU_OR;
          default: alu_sel = ALU_ADD;
        endcase
        state_nxt = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        case (bus.funct3)
          3'b111:  alu_sel = ALU_AND;
          3'b110:  alu_sel = ALU_OR;
          default: alu_sel = ALU_ADD;
        endcase
        state_nxt = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 2'b10;
        alu_sel   = ALU_SUB;
        // funct3[0] distinguishes bne from beq
        pc_write  = bus.funct3[0] ? ~bus.zero : bus.zero;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
        state_nxt = S_ALUWB;
      end
      default: state_nxt = S_FETCH;
    endcase

    if (rst) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
      illegal   = 1'b0;
    end
  end

  assign bus.pc_write   = pc_write;
  assign bus.adr_src    = adr_src;
  assign bus.mem_write  = mem_write;
  assign bus.ir_write   = ir_write;
  assign bus.result_src = result_src;
  assign bus.alu_src_a  = alu_src_a;
  assign bus.alu_src_b  = alu_src_b;
  assign bus.alu_sel    = alu_sel;
  assign bus.imm_src    = imm_src;
  assign bus.reg_write  = reg_write;
  assign bus.illegal    = illegal;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: stimulus queues the expected
// control word per cycle, a negedge monitor pops and compares.
module tb_multicycle_controller;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multicycle_controller_if bus ();
  multicycle_controller dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [16:0] vec;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
  //  alu_src_b, alu_sel, imm_src, reg_write, illegal}
  function automatic logic [16:0] v(input logic pw, input logic adr, input logic mw,
                                    input logic irw, input logic [1:0] rs,
                                    input logic [1:0] sa, input logic [1:0] sb,
                                    input logic [2:0] alu, input logic [1:0] imm,
                                    input logic rw, input logic ill);
    return {pw, adr, mw, irw, rs, sa, sb, alu, imm, rw, ill};
  endfunction

  function automatic logic [16:0] v_fetch(input logic [1:0] imm);
    return v(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, imm, 0, 0);
  endfunction
  function automatic logic [16:0] v_rst(input logic [1:0] imm);
    return v(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, imm, 0, 0);
  endfunction
  function automatic logic [16:0] v_dec(input logic [1:0] imm, input logic ill);
    return v(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, imm, 0, ill);
  endfunction
  function automatic logic [16:0] v_aluwb(input logic [1:0] imm);
    return v(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, imm, 1, 0);
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      logic [16:0] got;
      e   = exp_q.pop_front();
      got = {bus.pc_write, bus.adr_src, bus.mem_write, bus.ir_write, bus.result_src,
             bus.alu_src_a, bus.alu_src_b, bus.alu_sel, bus.imm_src, bus.reg_write,
             bus.illegal};
      checks++;
      if (got !== e.vec) begin
        failures++;
        $display("FAIL %s: got %b expected %b", e.name, got, e.vec);
      end
    end
  end

  task automatic cyc(input logic [16:0] vec, input string name);
    exp_t e;
    e.vec  = vec;
    e.name = name;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic set_ir(input logic [31:0] ir);
    bus.op       = ir[6:0];
    bus.funct3   = ir[14:12];
    bus.funct7b5 = ir[30];
  endtask

  initial begin
    rst      = 1'b1;
    bus.zero = 1'b0;
    set_ir(32'h00000013);
    @(posedge clk);
    #1;
    cyc(v_rst(2'b00), "reset0");
    cyc(v_rst(2'b00), "reset1");
    rst = 1'b0;

    // add x3,x1,x2 interrupted by reset in EXECR
    set_ir(32'h002081B3);
    cyc(v_fetch(2'b00), "add_fetch");
    cyc(v_dec(2'b00, 0), "add_decode");
    rst = 1'b1;
    cyc(v_rst(2'b00), "rst_mid_execr0");
    cyc(v_rst(2'b00), "rst_mid_execr1");
    rst = 1'b0;

    // sub x3,x1,x2
    set_ir(32'h402081B3);
    cyc(v_fetch(2'b00), "sub_fetch");
    cyc(v_dec(2'b00, 0), "sub_decode");
    cyc(v(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b00, 0, 0), "sub_execr");
    cyc(v_aluwb(2'b00), "sub_aluwb");

    // lw
    set_ir(32'h0040A183);
    cyc(v_fetch(2'b00), "lw_fetch");
    cyc(v_dec(2'b00, 0), "lw_decode");
    cyc(v(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00, 0, 0), "lw_memadr");
    cyc(v(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0, 0), "lw_memread");
    cyc(v(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 3'b000, 2'b00, 1, 0), "lw_memwb");

    // sw
    set_ir(32'h0030A223);
    cyc(v_fetch(2'b01), "sw_fetch");
    cyc(v_dec(2'b01, 0), "sw_decode");
    cyc(v(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b01, 0, 0), "sw_memadr");
    cyc(v(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 0, 0), "sw_memwrite");

    // beq / bne with both zero values
    for (int k = 0; k < 4; k++) begin
      logic bne_f, z, taken;
      bne_f    = k[1];
      z        = k[0];
      taken    = bne_f ? ~z : z;
      bus.zero = z;
      set_ir(bne_f ? 32'h00001063 : 32'h00000063);
      cyc(v_fetch(2'b10), "br_fetch");
      cyc(v_dec(2'b10, 0), "br_decode");
      cyc(v(taken, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b10, 0, 0),
          $sformatf("br_bne%0d_zero%0d", bne_f, z));
    end
    bus.zero = 1'b0;

    // jal
    set_ir(32'h008000EF);
    cyc(v_fetch(2'b11), "jal_fetch");
    cyc(v_dec(2'b11, 0), "jal_decode");
    cyc(v(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 2'b11, 0, 0), "jal_jal");
    cyc(v_aluwb(2'b11), "jal_aluwb");

    // illegal opcode
    set_ir(32'h0000007F);
    cyc(v_fetch(2'b00), "ill_op_fetch");
    cyc(v_dec(2'b00, 1), "ill_op_decode");

    // R-type funct3=001 is unsupported
    set_ir(32'h00001033);
    cyc(v_fetch(2'b00), "ill_r_fetch");
    cyc(v_dec(2'b00, 1), "ill_r_decode");

    // andi with funct7b5 set is still AND
    set_ir(32'h4FF0F093);
    cyc(v_fetch(2'b00), "andi_fetch");
    cyc(v_dec(2'b00, 0), "andi_decode");
    cyc(v(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b010, 2'b00, 0, 0), "andi_execi");
    cyc(v_aluwb(2'b00), "andi_aluwb");

    // ori
    set_ir(32'h0FF0E093);
    cyc(v_fetch(2'b00), "ori_fetch");
    cyc(v_dec(2'b00, 0), "ori_decode");
    cyc(v(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b011, 2'b00, 0, 0), "ori_execi");
    cyc(v_aluwb(2'b00), "ori_aluwb");

    cyc(v_fetch(2'b00), "final_fetch");

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
